// File: rtl/load_unit_pkg.sv
// Shared definitions for the load path: funct3 codes, lane sizes, FSM states,
// the latched load context, and legality helpers.
package load_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RD_W   = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned SIZE_W = 2;

  // RV32I load funct3 codes
  localparam logic [F3_W-1:0] LD_BYTE  = 3'b000;
  localparam logic [F3_W-1:0] LD_HALF  = 3'b001;
  localparam logic [F3_W-1:0] LD_WORD  = 3'b010;
  localparam logic [F3_W-1:0] LD_BYTEU = 3'b100;
  localparam logic [F3_W-1:0] LD_HALFU = 3'b101;

  // Lane size field (funct3[1:0]); same encoding as the store-width codes
  localparam logic [SIZE_W-1:0] SIZE_B  = 2'b00;
  localparam logic [SIZE_W-1:0] SIZE_H  = 2'b01;
  localparam logic [SIZE_W-1:0] SIZE_WD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_e;

  // Load attributes captured at accept time
  typedef struct packed {
    logic [F3_W-1:0] funct3;
    logic [1:0]      byte_off;
    logic [RD_W-1:0] rd;
  } load_ctx_t;

  function automatic logic is_illegal(input logic [F3_W-1:0] f3);
    return !(f3 inside {LD_BYTE, LD_HALF, LD_WORD, LD_BYTEU, LD_HALFU});
  endfunction

  function automatic logic is_misaligned(input logic [F3_W-1:0] f3,
                                         input logic [1:0]      off);
    return ((f3[1:0] == SIZE_H) && off[0]) ||
           ((f3[1:0] == SIZE_WD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_unit_extract.sv
// load_extract: selects the byte/halfword lane from a read word and sign- or
// zero-extends it to 32 bits. Purely combinational.
//   funct3   in  load funct3 (bit 2 = unsigned, bits 1:0 = lane size)
//   byte_off in  addr[1:0] of the load
//   word     in  32-bit word read from memory
//   result_c out extended result
module load_extract
  import load_unit_pkg::*;
(
  input  logic [F3_W-1:0] funct3,
  input  logic [1:0]      byte_off,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] result_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(word >> {byte_off, 3'b000});
    half_sel = 16'(word >> {byte_off[1], 4'b0000});
    result_c = word;
    case (funct3[1:0])
      SIZE_B:  result_c = funct3[2] ? {24'h0, byte_sel}
                                    : {{24{byte_sel[7]}}, byte_sel};
      SIZE_H:  result_c = funct3[2] ? {16'h0, half_sel}
                                    : {{16{half_sel[15]}}, half_sel};
      default: result_c = word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// load_unit: accepts a load from the memory stage, issues a word-aligned read,
// waits for variable-latency data, and returns the extended result.
//   load_req/load_ready      handshake from the memory stage (ready = IDLE)
//   funct3, addr, rd_addr    load attributes
//   mem_req/mem_addr/mem_ready    read request channel
//   mem_rvalid/mem_rdata          read response channel
//   load_valid/load_data/load_rd  one-cycle writeback result
//   misaligned, illegal, bus_error one-cycle error pulses
module load_unit
  import load_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_req,
  output logic            load_ready,
  input  logic [F3_W-1:0] funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [RD_W-1:0] rd_addr,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic [RD_W-1:0] load_rd,
  output logic            misaligned,
  output logic            illegal,
  output logic            bus_error
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  state_e           state;
  load_ctx_t        ctx;
  logic [CNT_W-1:0] wait_cnt;
  logic [XLEN-1:0]  ext_c;

  load_extract u_extract (
    .funct3   (ctx.funct3),
    .byte_off (ctx.byte_off),
    .word     (mem_rdata),
    .result_c (ext_c)
  );

  assign load_ready = (state == S_IDLE);

  // Load FSM with registered outputs; pulse outputs default low each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      ctx        <= '0;
      wait_cnt   <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      load_valid <= 1'b0;
      load_data  <= '0;
      load_rd    <= '0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_req) begin
            ctx      <= '{funct3: funct3, byte_off: addr[1:0], rd: rd_addr};
            mem_addr <= {addr[XLEN-1:2], 2'b00};
            if (is_illegal(funct3)) begin
              illegal <= 1'b1;
            end else if (is_misaligned(funct3, addr[1:0])) begin
              misaligned <= 1'b1;
            end else begin
              mem_req <= 1'b1;
              state   <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Data arriving in the final allowed cycle still wins over timeout
          if (mem_rvalid) begin
            load_data  <= ext_c;
            load_rd    <= ctx.rd;
            load_valid <= 1'b1;
            state      <= S_RESP;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            bus_error <= 1'b1;
            state     <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_RESP: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
